// File: rtl/pipe_buf_pkg.sv
// Shared pipeline constants: stage payload widths and base opcode encodings.
package pipe_buf_pkg;

  // Instruction word and program counter widths
  localparam int INSN_W = 32;
  localparam int PC_W   = 32;

  // Inter-stage payload widths
  localparam int IF_ID_W = INSN_W + PC_W;
  localparam int ID_EX_W = INSN_W + PC_W;
  localparam int EX_MA_W = INSN_W + PC_W;
  localparam int MA_WB_W = INSN_W + PC_W;

  // Base opcode field encodings (instruction bits [6:0])
  typedef enum logic [6:0] {
    OP_LOAD   = 7'b0000011,
    OP_IMM    = 7'b0010011,
    OP_AUIPC  = 7'b0010111,
    OP_STORE  = 7'b0100011,
    OP_REG    = 7'b0110011,
    OP_LUI    = 7'b0110111,
    OP_BRANCH = 7'b1100011,
    OP_JALR   = 7'b1100111,
    OP_JAL    = 7'b1101111
  } opcode_e;

  // IF/ID payload layout: instruction word in the upper half, PC in the lower
  typedef struct packed {
    logic [INSN_W-1:0] insn;
    logic [PC_W-1:0]   pc;
  } if_id_t;

endpackage

// File: rtl/pipe_buf_ram.sv
// Storage for pipe_buf: one write port, one synchronous read port.
module pipe_buf_ram
  import pipe_buf_pkg::*;
#(
  parameter int DATA_W = IF_ID_W,
  parameter int DEPTH  = 2,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Array write; contents are never reset because they are invisible while empty
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Registered read; output holds its value between reads and clears on reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/pipe_buf.sv
// Pipeline stage buffer: small FIFO with level requests and one-cycle ack pulses.
module pipe_buf
  import pipe_buf_pkg::*;
#(
  parameter int DATA_W = IF_ID_W,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [DATA_W-1:0] wdata,
  output logic              wack,
  input  logic              re,
  output logic [DATA_W-1:0] rdata,
  output logic              rack,
  output logic              avail,
  output logic              full,
  input  logic              flush
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [PTR_W-1:0] wptr_reg;
  logic [PTR_W-1:0] rptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic [CNT_W-1:0] count_next;
  logic             wack_reg;
  logic             rack_reg;
  logic             avail_reg;
  logic             full_reg;
  logic             wr_go;
  logic             rd_go;

  // A request is serviced only when its ack is low, so a held level is taken once;
  // full/avail are the registered pre-edge view of count.
  assign wr_go = we && !wack_reg && !full_reg  && !flush;
  assign rd_go = re && !rack_reg && avail_reg && !flush;

  // Occupancy after this edge; flush wins over everything
  always_comb begin
    count_next = count_reg;
    if (flush) begin
      count_next = '0;
    end else if (wr_go && !rd_go) begin
      count_next = count_reg + 1'b1;
    end else if (rd_go && !wr_go) begin
      count_next = count_reg - 1'b1;
    end
  end

  // Pointers, count, status flags and ack pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_reg  <= '0;
      rptr_reg  <= '0;
      count_reg <= '0;
      wack_reg  <= 1'b0;
      rack_reg  <= 1'b0;
      avail_reg <= 1'b0;
      full_reg  <= 1'b0;
    end else begin
      if (flush) begin
        wptr_reg <= '0;
        rptr_reg <= '0;
      end else begin
        if (wr_go) wptr_reg <= wptr_reg + 1'b1;
        if (rd_go) rptr_reg <= rptr_reg + 1'b1;
      end
      count_reg <= count_next;
      wack_reg  <= wr_go;
      rack_reg  <= rd_go;
      avail_reg <= (count_next != '0);
      full_reg  <= (count_next == CNT_W'(DEPTH));
    end
  end

  pipe_buf_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (PTR_W)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_go),
    .waddr (wptr_reg),
    .wdata (wdata),
    .re    (rd_go),
    .raddr (rptr_reg),
    .rdata (rdata)
  );

  assign wack  = wack_reg;
  assign rack  = rack_reg;
  assign avail = avail_reg;
  assign full  = full_reg;

endmodule

// File: tb/tb_pipe_buf.sv
// Directed self-checking bench for pipe_buf (DATA_W=64, DEPTH=2).
module tb_pipe_buf;

  logic        clk;
  logic        rst;
  logic        we;
  logic [63:0] wdata;
  logic        wack;
  logic        re;
  logic [63:0] rdata;
  logic        rack;
  logic        avail;
  logic        full;
  logic        flush;

  int checks = 0;
  int errors = 0;

  pipe_buf #(.DATA_W(64), .DEPTH(2)) dut (
    .clk   (clk),
    .rst   (rst),
    .we    (we),
    .wdata (wdata),
    .wack  (wack),
    .re    (re),
    .rdata (rdata),
    .rack  (rack),
    .avail (avail),
    .full  (full),
    .flush (flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Raise we with data, wait (bounded) for wack, then drop we
  task automatic do_write(input logic [63:0] d, input string nm);
    bit got;
    int n;
    got = 0;
    n = 0;
    @(negedge clk);
    we = 1'b1;
    wdata = d;
    while (!got && n < 20) begin
      @(posedge clk);
      #1;
      n++;
      if (wack) got = 1;
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL %s: wack not seen within %0d cycles, got wack=%b need 1", nm, n, wack);
    end
    @(negedge clk);
    we = 1'b0;
    $display("WRITE %s data=%h cycles=%0d", nm, d, n);
  endtask

  // Raise re, wait (bounded) for rack, compare rdata, drop re
  task automatic do_read(input logic [63:0] exp, input string nm);
    bit got;
    int n;
    got = 0;
    n = 0;
    @(negedge clk);
    re = 1'b1;
    while (!got && n < 20) begin
      @(posedge clk);
      #1;
      n++;
      if (rack) got = 1;
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL %s: rack not seen within %0d cycles, got rack=%b need 1", nm, n, rack);
    end
    checks++;
    if (rdata !== exp) begin
      errors++;
      $display("FAIL %s: rdata got %h need %h", nm, rdata, exp);
    end
    @(negedge clk);
    re = 1'b0;
    $display("READ %s data=%h cycles=%0d", nm, rdata, n);
  endtask

  task automatic test_reset();
    rst = 1'b1; we = 1'b0; re = 1'b0; flush = 1'b0; wdata = '0;
    #1;
    checks++;
    if ({wack, rack, avail, full} !== 4'b0000 || rdata !== 64'h0) begin
      errors++;
      $display("FAIL reset_state: wack=%b rack=%b avail=%b full=%b rdata=%h need all 0",
               wack, rack, avail, full, rdata);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    $display("RESET released");
  endtask

  task automatic test_single_write();
    @(negedge clk);
    we = 1'b1;
    wdata = 64'h00000013_00000000;
    @(posedge clk); #1;
    checks++;
    if (wack !== 1'b1 || avail !== 1'b1 || full !== 1'b0) begin
      errors++;
      $display("FAIL single_write: wack=%b avail=%b full=%b need 1 1 0", wack, avail, full);
    end
    @(negedge clk);
    we = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (wack !== 1'b0 || avail !== 1'b1) begin
      errors++;
      $display("FAIL wack_pulse: wack=%b avail=%b need 0 1", wack, avail);
    end
    $display("WRITE single data=0000001300000000");
    do_read(64'h00000013_00000000, "single_read");
    checks++;
    if (avail !== 1'b0) begin
      errors++;
      $display("FAIL single_empty: avail got %b need 0", avail);
    end
  endtask

  task automatic test_two_writes_reads();
    do_write(64'h11, "wr_A");
    do_write(64'h22, "wr_B");
    checks++;
    if (full !== 1'b1 || avail !== 1'b1) begin
      errors++;
      $display("FAIL two_full: full=%b avail=%b need 1 1", full, avail);
    end
    do_read(64'h11, "rd_A");
    checks++;
    if (avail !== 1'b1 || full !== 1'b0) begin
      errors++;
      $display("FAIL after_rd_A: avail=%b full=%b need 1 0", avail, full);
    end
    do_read(64'h22, "rd_B");
    checks++;
    if (avail !== 1'b0) begin
      errors++;
      $display("FAIL after_rd_B: avail got %b need 0", avail);
    end
  endtask

  task automatic test_full_hold();
    do_write(64'h44, "fill_0");
    do_write(64'h55, "fill_1");
    @(negedge clk);
    we = 1'b1;
    wdata = 64'h33;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if (wack !== 1'b0 || full !== 1'b1) begin
        errors++;
        $display("FAIL full_hold[%0d]: wack=%b full=%b need 0 1", i, wack, full);
      end
    end
    @(negedge clk);
    re = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (rack !== 1'b1 || rdata !== 64'h44 || wack !== 1'b0 || full !== 1'b0) begin
      errors++;
      $display("FAIL full_rd_wr: rack=%b rdata=%h wack=%b full=%b need 1 44 0 0",
               rack, rdata, wack, full);
    end
    @(negedge clk);
    re = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (wack !== 1'b1 || full !== 1'b1) begin
      errors++;
      $display("FAIL full_retry: wack=%b full=%b need 1 1", wack, full);
    end
    @(negedge clk);
    we = 1'b0;
    $display("WRITE held data=33 accepted after read");
    do_read(64'h55, "drain_55");
    do_read(64'h33, "drain_33");
    checks++;
    if (avail !== 1'b0) begin
      errors++;
      $display("FAIL drain_empty: avail got %b need 0", avail);
    end
  endtask

  task automatic test_simul_empty();
    @(negedge clk);
    we = 1'b1;
    re = 1'b1;
    wdata = 64'h88;
    @(posedge clk); #1;
    checks++;
    if (wack !== 1'b1 || rack !== 1'b0 || avail !== 1'b1) begin
      errors++;
      $display("FAIL simul_edge: wack=%b rack=%b avail=%b need 1 0 1", wack, rack, avail);
    end
    @(negedge clk);
    we = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (rack !== 1'b1 || rdata !== 64'h88 || avail !== 1'b0) begin
      errors++;
      $display("FAIL simul_read: rack=%b rdata=%h avail=%b need 1 88 0", rack, rdata, avail);
    end
    @(negedge clk);
    re = 1'b0;
    $display("WRITE+READ simultaneous on empty data=88");
  endtask

  task automatic test_flush();
    do_write(64'h66, "fl_wr0");
    do_write(64'h77, "fl_wr1");
    @(negedge clk);
    re = 1'b1;
    flush = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (rack !== 1'b0 || avail !== 1'b0 || full !== 1'b0 || rdata !== 64'h88) begin
      errors++;
      $display("FAIL flush: rack=%b avail=%b full=%b rdata=%h need 0 0 0 88",
               rack, avail, full, rdata);
    end
    @(negedge clk);
    re = 1'b0;
    flush = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (rack !== 1'b0 || avail !== 1'b0 || rdata !== 64'h88) begin
      errors++;
      $display("FAIL post_flush: rack=%b avail=%b rdata=%h need 0 0 88", rack, avail, rdata);
    end
    $display("FLUSH with re=1 discarded two entries");
    do_write(64'h99, "fl_wr2");
    do_read(64'h99, "fl_rd2");
  endtask

  task automatic test_reset_mid();
    // Reset while a write request is pending but before its accepting edge
    @(negedge clk);
    we = 1'b1;
    wdata = 64'hABC;
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({wack, rack, avail, full} !== 4'b0000 || rdata !== 64'h0) begin
      errors++;
      $display("FAIL rst_async: wack=%b rack=%b avail=%b full=%b rdata=%h need all 0",
               wack, rack, avail, full, rdata);
    end
    @(posedge clk);
    @(negedge clk);
    we = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (wack !== 1'b0 || avail !== 1'b0) begin
      errors++;
      $display("FAIL rst_no_ack: wack=%b avail=%b need 0 0", wack, avail);
    end
    // Reset while wack is high clears it at once
    @(negedge clk);
    we = 1'b1;
    wdata = 64'hBCD;
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    checks++;
    if (wack !== 1'b0 || avail !== 1'b0) begin
      errors++;
      $display("FAIL rst_during_ack: wack=%b avail=%b need 0 0", wack, avail);
    end
    @(negedge clk);
    we = 1'b0;
    rst = 1'b0;
    $display("RESET mid-handshake");
    do_write(64'hDEF, "fresh_wr");
    checks++;
    if (avail !== 1'b1 || full !== 1'b0) begin
      errors++;
      $display("FAIL fresh_state: avail=%b full=%b need 1 0", avail, full);
    end
    do_read(64'hDEF, "fresh_rd");
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_two_writes_reads();
    test_full_hold();
    test_simul_empty();
    test_flush();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
